// File: rtl/irq_pending_ctrl_if.sv
// Bundles the request/mask/handshake signals between the pending controller,
// the CPU side and the downstream priority encoder.
interface irq_pending_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDW   = 5
);
    logic [WIDTH-1:0] irq_in;
    logic             mask_wr;
    logic [WIDTH-1:0] mask_din;
    logic             ack;
    logic [IDW-1:0]   ack_id;
    logic             eoi;
    logic [WIDTH-1:0] pend_vec;
    logic             pend_valid;
    logic             irq_out;
    logic [IDW-1:0]   isr_id;
    logic             in_service;
    logic             ack_err;

    modport master (
        output irq_in, mask_wr, mask_din, ack, ack_id, eoi,
        input  pend_vec, pend_valid, irq_out, isr_id, in_service, ack_err
    );

    modport slave (
        input  irq_in, mask_wr, mask_din, ack, ack_id, eoi,
        output pend_vec, pend_valid, irq_out, isr_id, in_service, ack_err
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Sticky rising-edge pending register with mask, feeding a priority encoder,
// plus the IDLE/REQ/SERVICE request-ack-eoi handshake with the CPU.
module irq_pending_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    irq_pending_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] irq_prev_q;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IDW-1:0]   isr_id_q, isr_id_d;
    logic             ack_err_q, ack_err_d;

    logic [WIDTH-1:0] event_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] pend_vec;
    logic             pend_valid;
    logic             ack_hit;

    // Encoder-facing view is purely a function of registers.
    assign pend_vec   = pending_q & mask_q;
    assign pend_valid = |pend_vec;
    assign event_vec  = bus.irq_in & ~irq_prev_q;
    assign ack_hit    = pend_vec[bus.ack_id];

    assign mask_d     = bus.mask_wr ? bus.mask_din : mask_q;
    // Event set is applied after the ack clear so a colliding edge keeps the bit.
    assign pending_d  = (pending_q & ~clr_vec) | event_vec;

    always_comb begin
        state_d   = state_q;
        isr_id_d  = isr_id_q;
        ack_err_d = 1'b0;
        clr_vec   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack takes precedence; a simultaneous eoi has no meaning here
                if (bus.ack) begin
                    if (ack_hit) begin
                        state_d              = ST_SERVICE;
                        isr_id_d             = bus.ack_id;
                        clr_vec[bus.ack_id]  = 1'b1;
                    end else begin
                        ack_err_d = 1'b1;
                    end
                end else if (!pend_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            isr_id_q   <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= bus.irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            isr_id_q   <= isr_id_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign bus.pend_vec   = pend_vec;
    assign bus.pend_valid = pend_valid;
    assign bus.irq_out    = (state_q == ST_REQ);
    assign bus.in_service = (state_q == ST_SERVICE);
    assign bus.isr_id     = isr_id_q;
    assign bus.ack_err    = ack_err_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed vector bench for irq_pending_ctrl: per-cycle table plus a
// hand-written asynchronous reset sequence.
module tb_irq_pending_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDW   = 5;

    typedef struct {
        logic [WIDTH-1:0] irq;
        logic             mwr;
        logic [WIDTH-1:0] mdin;
        logic             ack;
        logic [IDW-1:0]   aid;
        logic             eoi;
        logic [WIDTH-1:0] e_pv;
        logic             e_irq;
        logic [IDW-1:0]   e_isr;
        logic             e_ins;
        logic             e_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    vec_t vecs[$];

    irq_pending_ctrl_if #(.WIDTH(WIDTH), .IDW(IDW)) bus ();

    irq_pending_ctrl #(.WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [WIDTH-1:0] irq, logic mwr, logic [WIDTH-1:0] mdin,
                                logic ack, logic [IDW-1:0] aid, logic eoi,
                                logic [WIDTH-1:0] pv, logic ir, logic [IDW-1:0] isr,
                                logic ins, logic err);
        vec_t v;
        v.irq = irq; v.mwr = mwr; v.mdin = mdin; v.ack = ack; v.aid = aid; v.eoi = eoi;
        v.e_pv = pv; v.e_irq = ir; v.e_isr = isr; v.e_ins = ins; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] pv, input logic ir,
                           input logic [IDW-1:0] isr, input logic ins, input logic err);
        chk({tag, " pend_vec"},   32'(bus.pend_vec),   32'(pv));
        chk({tag, " pend_valid"}, 32'(bus.pend_valid), 32'(|pv));
        chk({tag, " irq_out"},    32'(bus.irq_out),    32'(ir));
        chk({tag, " isr_id"},     32'(bus.isr_id),     32'(isr));
        chk({tag, " in_service"}, 32'(bus.in_service), 32'(ins));
        chk({tag, " ack_err"},    32'(bus.ack_err),    32'(err));
    endtask

    task automatic drive(input logic [WIDTH-1:0] irq, input logic mwr, input logic [WIDTH-1:0] mdin,
                         input logic ack, input logic [IDW-1:0] aid, input logic eoi);
        bus.irq_in   = irq;
        bus.mask_wr  = mwr;
        bus.mask_din = mdin;
        bus.ack      = ack;
        bus.ack_id   = aid;
        bus.eoi      = eoi;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        drive('0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Each record: inputs for one cycle, outputs expected after that edge.
        //                 irq           mwr  mdin          ack  aid  eoi  pend_vec      irq  isr  ins  err
        vecs.push_back(mk(32'h0,        1, 32'hFFFF_FFFF, 0, 5'd0,  0, 32'h0,         0, 5'd0,  0, 0)); // 0 mask all on
        vecs.push_back(mk(32'h80,       0, 32'h0,         0, 5'd0,  0, 32'h80,        0, 5'd0,  0, 0)); // 1 event bit 7
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h80,        1, 5'd0,  0, 0)); // 2 REQ
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd7,  0, 32'h0,         0, 5'd7,  1, 0)); // 3 ack 7
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h0,         0, 5'd7,  1, 0)); // 4
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h0,         0, 5'd7,  0, 0)); // 5 eoi
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h0,         0, 5'd7,  0, 0)); // 6 stays idle
        vecs.push_back(mk(32'h200,      0, 32'h0,         0, 5'd0,  0, 32'h200,       0, 5'd7,  0, 0)); // 7 event bit 9
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h200,       1, 5'd7,  0, 0)); // 8 REQ
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd4,  0, 32'h200,       1, 5'd7,  0, 1)); // 9 spurious ack
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h200,       1, 5'd7,  0, 0)); // 10 err one cycle
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd9,  0, 32'h0,         0, 5'd9,  1, 0)); // 11 ack 9
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd9,  0, 32'h0,         0, 5'd9,  1, 0)); // 12 ack ignored
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h0,         0, 5'd9,  0, 0)); // 13 eoi
        vecs.push_back(mk(32'h8000_0004,0, 32'h0,         0, 5'd0,  0, 32'h8000_0004, 0, 5'd9,  0, 0)); // 14 bits 31,2
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h8000_0004, 1, 5'd9,  0, 0)); // 15 REQ
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd31, 1, 32'h4,         0, 5'd31, 1, 0)); // 16 ack+eoi
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h4,         0, 5'd31, 0, 0)); // 17 eoi
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h4,         1, 5'd31, 0, 0)); // 18 REQ again
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd2,  0, 32'h0,         0, 5'd2,  1, 0)); // 19 ack 2
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h0,         0, 5'd2,  0, 0)); // 20 eoi
        vecs.push_back(mk(32'h0,        1, 32'h0,         0, 5'd0,  0, 32'h0,         0, 5'd2,  0, 0)); // 21 mask off
        vecs.push_back(mk(32'h8,        0, 32'h0,         0, 5'd0,  0, 32'h0,         0, 5'd2,  0, 0)); // 22 masked event
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h0,         0, 5'd2,  0, 0)); // 23
        vecs.push_back(mk(32'h0,        1, 32'h8,         0, 5'd0,  0, 32'h8,         0, 5'd2,  0, 0)); // 24 unmask bit 3
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h8,         1, 5'd2,  0, 0)); // 25 REQ
        vecs.push_back(mk(32'h0,        1, 32'h0,         0, 5'd0,  0, 32'h0,         1, 5'd2,  0, 0)); // 26 mask off in REQ
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h0,         0, 5'd2,  0, 0)); // 27 back to IDLE
        vecs.push_back(mk(32'h0,        1, 32'h8,         0, 5'd0,  0, 32'h8,         0, 5'd2,  0, 0)); // 28 unmask again
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h8,         1, 5'd2,  0, 0)); // 29 REQ
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd3,  0, 32'h0,         0, 5'd3,  1, 0)); // 30 ack 3
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h0,         0, 5'd3,  0, 0)); // 31 eoi
        vecs.push_back(mk(32'h0,        1, 32'hFFFF_FFFF, 1, 5'd0,  0, 32'h0,         0, 5'd3,  0, 0)); // 32 ack in IDLE
        vecs.push_back(mk(32'h20,       0, 32'h0,         0, 5'd0,  0, 32'h20,        0, 5'd3,  0, 0)); // 33 event bit 5
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h20,        1, 5'd3,  0, 0)); // 34 REQ
        vecs.push_back(mk(32'h20,       0, 32'h0,         1, 5'd5,  0, 32'h20,        0, 5'd5,  1, 0)); // 35 set/clear collide
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h20,        0, 5'd5,  0, 0)); // 36 eoi
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  0, 32'h20,        1, 5'd5,  0, 0)); // 37 REQ
        vecs.push_back(mk(32'h0,        0, 32'h0,         1, 5'd5,  0, 32'h0,         0, 5'd5,  1, 0)); // 38 ack 5
        vecs.push_back(mk(32'h0,        0, 32'h0,         0, 5'd0,  1, 32'h0,         0, 5'd5,  0, 0)); // 39 eoi

        #3;
        chk_all("reset", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].irq, vecs[i].mwr, vecs[i].mdin, vecs[i].ack, vecs[i].aid, vecs[i].eoi);
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_pv, vecs[i].e_irq, vecs[i].e_isr,
                    vecs[i].e_ins, vecs[i].e_err);
        end

        // Reset while in SERVICE with bits 0 and 1 pending, bit 1 held high throughout.
        drive(32'h3, 1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk("rs pend", 32'(bus.pend_vec), 32'h3);
        step();
        chk("rs req", 32'(bus.irq_out), 32'h1);
        drive(32'h3, 1'b0, '0, 1'b1, 5'd0, 1'b0);
        step();
        chk("rs ack0 pend", 32'(bus.pend_vec), 32'h2);
        drive(32'h2, 1'b0, '0, 1'b0, '0, 1'b0);
        step();
        drive(32'h3, 1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk_all("rs pre", 32'h3, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(32'h2, 1'b0, '0, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rs async", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_all("rs held", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(32'h2, 1'b1, 32'h2, 1'b0, '0, 1'b0);
        step();
        chk_all("rs rel", 32'h2, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(32'h2, 1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk_all("rs req2", 32'h2, 1'b1, 5'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Interrupt pending/handshake controller that sits directly upstream of the 32-input priority encoder. It detects rising edges on 32 request lines, holds them as sticky pending bits, applies a programmable mask, and drives the encoder's `A` vector and `en`. It also runs the request/acknowledge/end-of-interrupt handshake with the CPU, using the encoder's 5-bit index as the acknowledge ID.

## Interface
- `WIDTH`, 32: number of request lines. Must equal the encoder input width.
- `IDW`, 5: index width. Must equal clog2(`WIDTH`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq_in` in `WIDTH`: request lines, synchronous to `clk`. A 0→1 transition is an event.
- `mask_wr` in 1: load enable for the mask register.
- `mask_din` in `WIDTH`: new mask value. 1 = enabled.
- `ack` in 1: CPU acknowledge, 1-cycle pulse.
- `ack_id` in `IDW`: index being acknowledged. Driven from the encoder `Y`.
- `eoi` in 1: end-of-interrupt, 1-cycle pulse.
- `pend_vec` out `WIDTH`: `pending & mask`. Feeds encoder `A`.
- `pend_valid` out 1: OR-reduction of `pend_vec`. Feeds encoder `en`.
- `irq_out` out 1: interrupt request to the CPU.
- `isr_id` out `IDW`: index currently in service.
- `in_service` out 1: high while in state SERVICE.
- `ack_err` out 1: 1-cycle pulse on a spurious acknowledge.

## Operation
- **Edge detect:** register `irq_prev <= irq_in`. Event on bit i when `irq_in[i] & ~irq_prev[i]`.
- **Pending set:** a bit becomes pending on its event regardless of mask. Masked bits stay latched and appear on `pend_vec` once unmasked.
- **Pending clear:** only the accepted ack clears a bit, at `ack_id`. Nothing else clears pending.
- **Set/clear collision:** if set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- **Mask load:** `mask_wr` loads `mask_din` at the next edge. `pend_vec` and `pend_valid` update in the same cycle the new mask becomes visible.
- **Output paths:** `pend_vec` and `pend_valid` are combinational from registers. There is no path from any input to them.
- **FSM:** three states, IDLE, REQ and SERVICE. `irq_out` = (state == REQ). `in_service` = (state == SERVICE).
  - IDLE: `pend_valid` → REQ. `ack` and `eoi` are ignored.
  - REQ, on `ack` with `pend_vec[ack_id]` = 1: capture `isr_id <= ack_id`, clear `pending[ack_id]`, go to SERVICE.
  - REQ, on `ack` with `pend_vec[ack_id]` = 0: pulse `ack_err`, no state or pending change.
  - REQ, with `pend_valid` = 0 and no ack (all sources masked off): go to IDLE.
  - SERVICE: `eoi` → IDLE. `ack` is ignored and does not pulse `ack_err`. New events keep latching.
  - SERVICE → IDLE → REQ: after `eoi`, REQ re-asserts one cycle later if anything is still pending.
- **Ack/eoi together in REQ:** `ack` is processed and `eoi` is ignored.
- **ack_id range:** `ack_id` is always below `WIDTH`, since `IDW` is exact.

## Timing
- **Reset values** (asynchronous, all registers): `pending`=0, `mask`=0 (all masked), `irq_prev`=0, state=IDLE, `isr_id`=0. Resulting outputs: `pend_vec`=0, `pend_valid`=0, `irq_out`=0, `in_service`=0, `ack_err`=0.
- **Reset over a high line:** a line already high when `rst` releases produces an event on the first edge, because `irq_prev`=0.
- **Event to pending:** an event sampled at edge t is visible on `pend_vec` after edge t.
- **Pending to request:** `irq_out` rises after edge t+1. Event-to-`irq_out` latency is 2 cycles.
- **Ack at edge a:** after edge a, `irq_out`=0, `in_service`=1, `isr_id` is valid and the pending bit is clear.
- **ack_err timing:** `ack_err` is registered and high for the cycle after edge a.
- **eoi at edge e:** `in_service`=0 after edge e. `irq_out` can be 1 at the earliest after edge e+1.
- **Reset mid-handshake:** `rst` asserted in any state forces IDLE immediately and drops all pending bits.

## Test plan
- **Basic flow:** reset; mask=0xFFFFFFFF; pulse `irq_in[7]` → `pend_vec`=0x80 at cycle 1, `irq_out`=1 at cycle 2. Ack with `ack_id`=7 → `isr_id`=7, `in_service`=1, `pend_vec`=0. `eoi` → IDLE, `irq_out` stays 0.
- **Masked source:** mask=0; pulse `irq_in[3]` → `pend_vec`=0, `irq_out`=0. Write mask=0x8 → `pend_vec`=0x8, `irq_out`=1 one cycle later.
- **Two sources:** raise bits 31 and 2 together, ack 31, `eoi` → `pend_vec`=0x4 and REQ re-entered one cycle after `eoi`. Ack 2 → `pend_vec`=0.
- **Set/clear collision:** in REQ with bit 5 pending, re-pulse `irq_in[5]` (low then high) so its edge lands in the ack cycle → bit 5 still set after the ack, `in_service`=1.
- **Spurious ack:** in REQ with only bit 9 pending, `ack` with `ack_id`=4 → `ack_err`=1 for one cycle, state REQ, `pend_vec`=0x200.
- **Reset mid-operation:** `rst` in SERVICE with bits 0 and 1 pending → all outputs 0 asynchronously. With `irq_in[1]` held high across the reset, `pend_vec`=0x2 one cycle after release, once the mask is rewritten to 0x2.
